// File: rtl/sync_mem_pkg.sv
// Shared types for sync_mem: clear-sweep sequencer state encoding.
package sync_mem_pkg;
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;
endpackage

// File: rtl/sync_mem_init.sv
// Clear sequencer for sync_mem: sweeps every word address once after reset,
// then holds READY until the next reset.
module sync_mem_init
  import sync_mem_pkg::*;
#(
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_clr_en,
  output logic [AWIDTH-1:0] o_clr_ptr,
  output logic              o_init_done
);

  state_e            r_state, w_state_nxt;
  logic [AWIDTH-1:0] r_clr_ptr, w_clr_ptr_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    o_clr_en      = 1'b0;
    o_init_done   = 1'b0;
    case (r_state)
      CLEAR: begin
        o_clr_en      = 1'b1;
        w_clr_ptr_nxt = r_clr_ptr + 1'b1;
        if (r_clr_ptr == {AWIDTH{1'b1}}) w_state_nxt = READY;
      end
      READY: o_init_done = 1'b1;
      default: w_state_nxt = CLEAR;
    endcase
  end

  assign o_clr_ptr = r_clr_ptr;

endmodule

// File: rtl/sync_mem.sv
// Byte-enabled 1R1W synchronous memory with a post-reset zero sweep.
// Define SYNC_MEM_BYPASS_EN to forward same-address write data to the read port.
module sync_mem
  import sync_mem_pkg::*;
#(
  parameter  int AWIDTH = 8,
  parameter  int DWIDTH = 8,
  localparam int DEPTH  = 1 << AWIDTH,
  localparam int NBYTES = DWIDTH / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic [NBYTES-1:0] wr_be,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_valid,
  output logic              init_done
);

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [DWIDTH-1:0] r_rd_data;
  logic              r_rd_valid;

  logic              w_clr_en, w_ready;
  logic [AWIDTH-1:0] w_clr_ptr;
  logic              w_we;
  logic [AWIDTH-1:0] w_we_addr;
  logic [DWIDTH-1:0] w_we_data;
  logic [NBYTES-1:0] w_we_be;
  logic [DWIDTH-1:0] w_rd_word;

  sync_mem_init #(.AWIDTH(AWIDTH)) u_init (
    .clk        (clk),
    .rst        (rst),
    .o_clr_en   (w_clr_en),
    .o_clr_ptr  (w_clr_ptr),
    .o_init_done(w_ready)
  );

  // Sweep owns the write port until READY; the reset edge itself never writes.
  always_comb begin
    w_we      = 1'b0;
    w_we_addr = wr_addr;
    w_we_data = wr_data;
    w_we_be   = wr_be;
    if (!w_ready) begin
      w_we      = w_clr_en;
      w_we_addr = w_clr_ptr;
      w_we_data = '0;
      w_we_be   = '1;
    end else begin
      w_we = wr_en;
    end
    if (rst) w_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < NBYTES; i++)
        if (w_we_be[i]) r_mem[w_we_addr][8*i +: 8] <= w_we_data[8*i +: 8];
    end
  end

  always_comb begin
    w_rd_word = r_mem[rd_addr];
`ifdef SYNC_MEM_BYPASS_EN
    if (wr_en && (wr_addr == rd_addr)) begin
      for (int i = 0; i < NBYTES; i++)
        if (wr_be[i]) w_rd_word[8*i +: 8] = wr_data[8*i +: 8];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_ready & rd_en;
      if (w_ready && rd_en) r_rd_data <= w_rd_word;
    end
  end

  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign init_done = w_ready;

endmodule
